// File: rtl/write_channels_slave_pkg.sv
// Shared widths and FSM encoding for the write-channel responder.
//   ADDR_W/ID_W   : address and transaction id widths
//   DATA_W/BEATS  : W beat width and beats per line
//   LINE_W/MASK_W : assembled line width and its byte-mask width
//   state_t       : responder FSM state encoding
package write_channels_slave_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned ID_W        = 4;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BEATS       = 4;
  localparam int unsigned LINE_W      = DATA_W * BEATS;
  localparam int unsigned MASK_W      = LINE_W / 8;
  localparam int unsigned SLOT_MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W       = $clog2(BEATS) + 1;
  localparam int unsigned LINE_OFS_W  = $clog2(MASK_W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DATA  = 3'd1,
    S_LINE  = 3'd2,
    S_DRAIN = 3'd3,
    S_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/write_channels_slave_line_assembler.sv
// Collects W beats into one line and tracks which bytes were written.
//   clk, rst : clock and synchronous active-high reset
//   clear    : start a new line (data 0, all bytes masked, count 0)
//   wr_en    : accepted beat; ignored once the line is full
//   wdata    : beat data, placed in slot cnt
//   cnt      : beats captured so far, saturates at BEATS
//   line     : assembled line, beat n at bits [DATA_W*n +: DATA_W]
//   mask     : byte mask, 1 = byte not written
module write_channels_slave_line_assembler
  import write_channels_slave_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wdata,
  output logic [CNT_W-1:0]  cnt,
  output logic [LINE_W-1:0] line,
  output logic [MASK_W-1:0] mask
);

  // Slot write and byte-mask clear; the guard keeps the counter from wrapping
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt  <= '0;
      line <= '0;
      mask <= '1;
    end else if (wr_en && (cnt < CNT_W'(BEATS))) begin
      for (int unsigned i = 0; i < BEATS; i++) begin
        if (cnt == CNT_W'(i)) begin
          line[i*DATA_W +: DATA_W]           <= wdata;
          mask[i*SLOT_MASK_W +: SLOT_MASK_W] <= '0;
        end
      end
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/write_channels_slave.sv
// AW/W/B subordinate: takes one address, gathers a line of W beats, writes
// it on the line-write port, then answers on B. One transaction in flight.
//   clk, rst                      : clock, synchronous active-high reset
//   awvalid/awready/awid/awaddr/awatop : write address channel
//   wvalid/wready/wdata/wlast     : write data channel
//   bvalid/bready/bid/bcomp       : write response (bcomp 1 = OK)
//   lw_valid/lw_ready/lw_addr/lw_data/lw_mask : line write toward memory
module write_channels_slave
  import write_channels_slave_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [5:0]        awatop,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wlast,
  output logic              bvalid,
  input  logic              bready,
  output logic [ID_W-1:0]   bid,
  output logic              bcomp,
  output logic              lw_valid,
  input  logic              lw_ready,
  output logic [ADDR_W-1:0] lw_addr,
  output logic [LINE_W-1:0] lw_data,
  output logic [MASK_W-1:0] lw_mask
);

  state_t           state_q;
  state_t           state_d;
  logic             aw_hs;
  logic             w_hs;
  logic             lw_hs;
  logic             b_hs;
  logic             atop_err_q;
  logic             ovf_err_q;
  logic [CNT_W-1:0] cnt;
  logic             last_slot;
  logic             awready_d;
  logic             wready_d;
  logic             lw_valid_d;
  logic             bvalid_d;
  logic             bcomp_d;

  assign aw_hs     = awvalid & awready;
  assign w_hs      = wvalid & wready;
  assign lw_hs     = lw_valid & lw_ready;
  assign b_hs      = bvalid & bready;
  assign last_slot = (cnt == CNT_W'(BEATS - 1));

  write_channels_slave_line_assembler u_line (
    .clk   (clk),
    .rst   (rst),
    .clear (aw_hs),
    .wr_en (w_hs && (state_q == S_DATA)),
    .wdata (wdata),
    .cnt   (cnt),
    .line  (lw_data),
    .mask  (lw_mask)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (aw_hs) state_d = S_DATA;
      S_DATA: begin
        if (w_hs) begin
          if (wlast)          state_d = atop_err_q ? S_RESP : S_LINE;
          else if (last_slot) state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (w_hs && wlast) state_d = S_RESP;
      S_LINE:  if (lw_hs) state_d = S_RESP;
      S_RESP:  if (b_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so the handshake outputs are flops
  always_comb begin
    awready_d  = (state_d == S_IDLE);
    wready_d   = (state_d == S_DATA) || (state_d == S_DRAIN);
    lw_valid_d = (state_d == S_LINE);
    bvalid_d   = (state_d == S_RESP);
    bcomp_d    = bcomp;
    // Status is fixed on entry to RESP and held until the response leaves
    if ((state_d == S_RESP) && (state_q != S_RESP)) begin
      bcomp_d = ~atop_err_q & ~ovf_err_q;
    end
  end

  // Output and transaction-context registers
  always_ff @(posedge clk) begin
    if (rst) begin
      awready    <= 1'b1;
      wready     <= 1'b0;
      lw_valid   <= 1'b0;
      bvalid     <= 1'b0;
      bcomp      <= 1'b0;
      bid        <= '0;
      lw_addr    <= '0;
      atop_err_q <= 1'b0;
      ovf_err_q  <= 1'b0;
    end else begin
      awready  <= awready_d;
      wready   <= wready_d;
      lw_valid <= lw_valid_d;
      bvalid   <= bvalid_d;
      bcomp    <= bcomp_d;
      if (aw_hs) begin
        bid        <= awid;
        lw_addr    <= {awaddr[ADDR_W-1:LINE_OFS_W], LINE_OFS_W'(0)};
        atop_err_q <= (awatop != 6'd0);
        ovf_err_q  <= 1'b0;
      end else if ((state_q == S_DATA) && (state_d == S_DRAIN)) begin
        ovf_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_write_channels_slave.sv
// Directed bench for write_channels_slave: full line, short burst, line and
// response back-pressure, atomic and overlong bursts, mid-burst reset and
// back-to-back addresses with awvalid held.
module tb_write_channels_slave;
  import write_channels_slave_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [ID_W-1:0]   awid = '0;
  logic [ADDR_W-1:0] awaddr = '0;
  logic [5:0]        awatop = '0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [DATA_W-1:0] wdata = '0;
  logic              wlast = 1'b0;
  logic              bvalid;
  logic              bready = 1'b0;
  logic [ID_W-1:0]   bid;
  logic              bcomp;
  logic              lw_valid;
  logic              lw_ready = 1'b1;
  logic [ADDR_W-1:0] lw_addr;
  logic [LINE_W-1:0] lw_data;
  logic [MASK_W-1:0] lw_mask;

  int n_checks = 0;
  int n_errors = 0;
  int lw_cycles = 0;

  localparam logic [127:0] LINE1 = 128'h44444444_33333333_22222222_11111111;

  write_channels_slave dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awatop(awatop),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bcomp(bcomp),
    .lw_valid(lw_valid), .lw_ready(lw_ready), .lw_addr(lw_addr),
    .lw_data(lw_data), .lw_mask(lw_mask)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (lw_valid) lw_cycles++;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                       input logic [5:0] atop);
    int n = 0;
    awvalid = 1'b1; awid = id; awaddr = addr; awatop = atop;
    while (!awready && n < 50) begin tick(); n++; end
    chk("aw_ready_wait", awready, 1'b1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic last);
    int n = 0;
    wvalid = 1'b1; wdata = d; wlast = last;
    while (!wready && n < 50) begin tick(); n++; end
    chk("w_ready_wait", wready, 1'b1);
    tick();
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic take_resp(input logic [ID_W-1:0] id, input logic comp);
    chk("b_valid", bvalid, 1'b1);
    chk("b_id", bid, id);
    chk("b_comp", bcomp, comp);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("b_drop", bvalid, 1'b0);
    chk("aw_ready_after_b", awready, 1'b1);
  endtask

  task automatic full_txn(input string tag);
    do_aw(4'd3, 32'hdeadbeef, 6'd0);
    chk({tag, "_wready"}, wready, 1'b1);
    chk({tag, "_awready_busy"}, awready, 1'b0);
    send_beat(32'h1111_1111, 1'b0);
    send_beat(32'h2222_2222, 1'b0);
    send_beat(32'h3333_3333, 1'b0);
    send_beat(32'h4444_4444, 1'b1);
    chk({tag, "_lw_valid"}, lw_valid, 1'b1);
    chk({tag, "_lw_addr"}, lw_addr, 32'hdeadbee0);
    chk({tag, "_lw_data"}, lw_data, LINE1);
    chk({tag, "_lw_mask"}, lw_mask, 16'h0000);
    chk({tag, "_no_b_yet"}, bvalid, 1'b0);
    tick();
    chk({tag, "_lw_drop"}, lw_valid, 1'b0);
    take_resp(4'd3, 1'b1);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_awready"}, awready, 1'b1);
    chk({tag, "_wready"}, wready, 1'b0);
    chk({tag, "_bvalid"}, bvalid, 1'b0);
    chk({tag, "_bid"}, bid, 4'd0);
    chk({tag, "_bcomp"}, bcomp, 1'b0);
    chk({tag, "_lw_valid"}, lw_valid, 1'b0);
    chk({tag, "_lw_addr"}, lw_addr, 32'd0);
    chk({tag, "_lw_data"}, lw_data, 128'd0);
    chk({tag, "_lw_mask"}, lw_mask, 16'hffff);
  endtask

  initial begin
    int lw_before;
    logic [127:0] held;

    tick(); tick();
    rst = 1'b0;
    reset_checks("rst");

    // 1: full line, no stalls
    full_txn("t1");

    // 2: short burst; a W beat offered together with AW waits for DATA
    awvalid = 1'b1; awid = 4'd5; awaddr = 32'h1000_0024; awatop = 6'd0;
    wvalid = 1'b1; wdata = 32'hAAAA_AAAA; wlast = 1'b0;
    chk("t2_w_idle_blocked", wready, 1'b0);
    tick();
    awvalid = 1'b0;
    chk("t2_wready", wready, 1'b1);
    tick();
    wdata = 32'hBBBB_BBBB; wlast = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    chk("t2_lw_valid", lw_valid, 1'b1);
    chk("t2_lw_addr", lw_addr, 32'h1000_0020);
    chk("t2_lw_data", lw_data, {64'd0, 64'hBBBBBBBB_AAAAAAAA});
    chk("t2_lw_mask", lw_mask, 16'hff00);
    tick();
    take_resp(4'd5, 1'b1);

    // 3: line-write and response back-pressure
    lw_ready = 1'b0;
    do_aw(4'd7, 32'h0000_0104, 6'd0);
    send_beat(32'h1111_1111, 1'b0);
    send_beat(32'h2222_2222, 1'b0);
    send_beat(32'h3333_3333, 1'b0);
    send_beat(32'h4444_4444, 1'b1);
    held = lw_data;
    chk("t3_line", held, LINE1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_lw_hold_valid", lw_valid, 1'b1);
      chk("t3_lw_hold_data", lw_data, LINE1);
      chk("t3_lw_hold_addr", lw_addr, 32'h0000_0100);
      chk("t3_lw_hold_mask", lw_mask, 16'h0000);
      chk("t3_no_b", bvalid, 1'b0);
      tick();
    end
    lw_ready = 1'b1;
    chk("t3_lw_still", lw_valid, 1'b1);
    tick();
    chk("t3_lw_drop", lw_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t3_b_hold_valid", bvalid, 1'b1);
      chk("t3_b_hold_id", bid, 4'd7);
      chk("t3_b_hold_comp", bcomp, 1'b1);
      tick();
    end
    take_resp(4'd7, 1'b1);

    // 4a: unsupported atomic op, no line write
    lw_before = lw_cycles;
    do_aw(4'd9, 32'h0000_2000, 6'h20);
    send_beat(32'h1, 1'b0);
    send_beat(32'h2, 1'b0);
    send_beat(32'h3, 1'b0);
    send_beat(32'h4, 1'b1);
    take_resp(4'd9, 1'b0);
    chk("t4a_no_lw", lw_cycles - lw_before, 0);

    // 4b: six beats without early wlast, extra beats drained
    lw_before = lw_cycles;
    do_aw(4'd10, 32'h0000_3000, 6'd0);
    for (int i = 1; i <= 6; i++) send_beat(DATA_W'(i), (i == 6));
    take_resp(4'd10, 1'b0);
    chk("t4b_no_lw", lw_cycles - lw_before, 0);

    // 5: reset in the middle of a burst
    do_aw(4'd4, 32'h0000_4000, 6'd0);
    send_beat(32'h5555_5555, 1'b0);
    wvalid = 1'b1; wdata = 32'h6666_6666; rst = 1'b1;
    tick();
    rst = 1'b0; wvalid = 1'b0;
    reset_checks("t5");
    lw_before = lw_cycles;
    tick(); tick(); tick();
    chk("t5_no_lw", lw_cycles - lw_before, 0);
    chk("t5_no_b", bvalid, 1'b0);
    full_txn("t5_after");

    // 6: back-to-back AWs with awvalid held
    awvalid = 1'b1; awid = 4'd1; awaddr = 32'h0000_5000; awatop = 6'd0;
    tick();
    awid = 4'd2; awaddr = 32'h0000_6000;
    for (int i = 0; i < 4; i++) begin
      chk("t6_aw_blocked", awready, 1'b0);
      send_beat(DATA_W'(32'h100 + i), (i == 3));
    end
    chk("t6_lw1_addr", lw_addr, 32'h0000_5000);
    chk("t6_aw_blocked_line", awready, 1'b0);
    tick();
    chk("t6_aw_blocked_resp", awready, 1'b0);
    chk("t6_bid1", bid, 4'd1);
    take_resp(4'd1, 1'b1);
    tick();
    awvalid = 1'b0;
    chk("t6_aw2_taken", awready, 1'b0);
    chk("t6_wready2", wready, 1'b1);
    for (int i = 0; i < 4; i++) send_beat(DATA_W'(32'h200 + i), (i == 3));
    chk("t6_lw2_addr", lw_addr, 32'h0000_6000);
    chk("t6_lw2_data", lw_data, 128'h00000203_00000202_00000201_00000200);
    tick();
    take_resp(4'd2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
